// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment readback path: glyph table, bus width, FSM states.
// Segment order is {G,F,E,D,C,B,A}, A at bit 0, 1 = lit.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK   = 7'h00;
  localparam seg_t SEG_GLYPH_0 = 7'h3F;
  localparam seg_t SEG_GLYPH_1 = 7'h06;
  localparam seg_t SEG_GLYPH_2 = 7'h5B;
  localparam seg_t SEG_GLYPH_3 = 7'h4F;
  localparam seg_t SEG_GLYPH_4 = 7'h66;
  localparam seg_t SEG_GLYPH_5 = 7'h6D;
  localparam seg_t SEG_GLYPH_6 = 7'h7D;
  localparam seg_t SEG_GLYPH_7 = 7'h07;
  localparam seg_t SEG_GLYPH_8 = 7'h7F;
  localparam seg_t SEG_GLYPH_9 = 7'h6F;
  localparam seg_t SEG_GLYPH_A = 7'h77;
  localparam seg_t SEG_GLYPH_B = 7'h7C;
  localparam seg_t SEG_GLYPH_C = 7'h39;
  localparam seg_t SEG_GLYPH_D = 7'h5E;
  localparam seg_t SEG_GLYPH_E = 7'h79;
  localparam seg_t SEG_GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_SETTLING = 2'd1,
    S_LOCKED   = 2'd2
  } seg_state_e;

  // Result of a pattern lookup: hit is set only for one of the 16 hex glyphs.
  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             hit;
  } seg_decode_t;

  function automatic logic seg_is_blank(input seg_t seg);
    return seg == SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational segment-pattern to hex-nibble lookup, shared by any segment reader.
module seg_glyph_lookup
  import seven_seg_pkg::*;
(
  input  logic        seg_i,
  input  seg_t        pattern_i,
  output seg_decode_t dec_c_o
);

  logic unused_c;
  assign unused_c = seg_i;

  always_comb begin
    dec_c_o = '{nibble: 4'h0, hit: 1'b1};
    case (pattern_i)
      SEG_GLYPH_0: dec_c_o.nibble = 4'h0;
      SEG_GLYPH_1: dec_c_o.nibble = 4'h1;
      SEG_GLYPH_2: dec_c_o.nibble = 4'h2;
      SEG_GLYPH_3: dec_c_o.nibble = 4'h3;
      SEG_GLYPH_4: dec_c_o.nibble = 4'h4;
      SEG_GLYPH_5: dec_c_o.nibble = 4'h5;
      SEG_GLYPH_6: dec_c_o.nibble = 4'h6;
      SEG_GLYPH_7: dec_c_o.nibble = 4'h7;
      SEG_GLYPH_8: dec_c_o.nibble = 4'h8;
      SEG_GLYPH_9: dec_c_o.nibble = 4'h9;
      SEG_GLYPH_A: dec_c_o.nibble = 4'hA;
      SEG_GLYPH_B: dec_c_o.nibble = 4'hB;
      SEG_GLYPH_C: dec_c_o.nibble = 4'hC;
      SEG_GLYPH_D: dec_c_o.nibble = 4'hD;
      SEG_GLYPH_E: dec_c_o.nibble = 4'hE;
      SEG_GLYPH_F: dec_c_o.nibble = 4'hF;
      default:     dec_c_o.hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_to_nibble.sv
// Debounced 7-segment pattern decoder: accepts a pattern after STABLE_CYCLES identical samples.
// Optional SEG_DECODE_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module seven_seg_to_nibble
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [SEG_W-1:0] i_Segments,
  output logic [NIB_W-1:0] o_Nibble,
  output logic             o_Valid,
  output logic             o_Invalid,
  output logic             o_Change
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);

  seg_t             seg_in_c;
  seg_t             seg_q;
  seg_t             cand_q,    cand_d;
  seg_t             last_q,    last_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  seg_state_e       state_q,   state_d;
  logic [NIB_W-1:0] nibble_q,  nibble_d;
  logic             valid_q,   valid_d;
  logic             invalid_q, invalid_d;
  logic             change_q,  change_d;
  seg_decode_t      dec_c;

`ifdef SEG_DECODE_SYNC_EN
  seg_t sync1_q, sync2_q;

  // Two-flop synchronizer for segment sources not clocked by i_Clk.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= i_Segments;
      sync2_q <= sync1_q;
    end
  end

  assign seg_in_c = sync2_q;
`else
  assign seg_in_c = i_Segments;
`endif

  seg_glyph_lookup u_lookup (
    .seg_i     (1'b0),
    .pattern_i (cand_q),
    .dec_c_o   (dec_c)
  );

  // Next-state: reload on any difference, commit once the count reaches threshold.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    nibble_d  = nibble_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    change_d  = 1'b0;

    if (seg_q != cand_q) begin
      cand_d  = seg_q;
      cnt_d   = CNT_W'(1);
      state_d = S_SETTLING;
    end else if ((state_q != S_LOCKED) && (cnt_q == CNT_COMMIT)) begin
      state_d  = S_LOCKED;
      last_d   = cand_q;
      change_d = (cand_q != last_q);
      if (dec_c.hit) begin
        nibble_d  = dec_c.nibble;
        valid_d   = 1'b1;
        invalid_d = 1'b0;
      end else begin
        // Blank keeps the nibble and clears both flags; other non-glyphs are invalid.
        valid_d   = 1'b0;
        invalid_d = !seg_is_blank(cand_q);
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg_q     <= SEG_BLANK;
      cand_q    <= SEG_BLANK;
      last_q    <= SEG_BLANK;
      cnt_q     <= '0;
      state_q   <= S_UNLOCKED;
      nibble_q  <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      seg_q     <= seg_in_c;
      cand_q    <= cand_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      nibble_q  <= nibble_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      change_q  <= change_d;
    end
  end

  assign o_Nibble  = nibble_q;
  assign o_Valid   = valid_q;
  assign o_Invalid = invalid_q;
  assign o_Change  = change_q;

endmodule

// File: tb/tb_seven_seg_to_nibble.sv
// Directed self-checking bench for seven_seg_to_nibble (default STABLE_CYCLES = 4).
module tb_seven_seg_to_nibble;

`ifdef SEG_DECODE_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] segs;
  logic [3:0] nibble;
  logic       valid;
  logic       invalid;
  logic       change;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_to_nibble #(.STABLE_CYCLES(4)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Segments (segs),
    .o_Nibble   (nibble),
    .o_Valid    (valid),
    .o_Invalid  (invalid),
    .o_Change   (change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] nib, input logic v,
                           input logic inv, input logic chg);
    check({tag, ".nibble"},  32'(nibble),  32'(nib));
    check({tag, ".valid"},   32'(valid),   32'(v));
    check({tag, ".invalid"}, 32'(invalid), 32'(inv));
    check({tag, ".change"},  32'(change),  32'(chg));
  endtask

  initial begin
    rst_n = 1'b0;
    segs  = 7'h00;
    cycles(2);
    check_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Static blank after reset: never pulses change.
    for (int c = 0; c < 10; c++) begin
      cycles(1);
      check_out("blank_idle", 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // 5B -> nibble 2 after LAT cycles, one-cycle change.
    segs = 7'h5B;
    cycles(LAT - 1);
    check_out("g2_early", 4'h0, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_out("g2_commit", 4'h2, 1'b1, 1'b0, 1'b1);
    cycles(1);
    check_out("g2_after", 4'h2, 1'b1, 1'b0, 1'b0);
    cycles(3);

    // 3-sample glitch of 7F must never commit.
    segs = 7'h7F;
    cycles(3);
    segs = 7'h5B;
    for (int c = 0; c < LAT + 6; c++) begin
      cycles(1);
      check_out("glitch", 4'h2, 1'b1, 1'b0, 1'b0);
    end

    // Non-glyph 49: invalid, nibble held.
    segs = 7'h49;
    cycles(LAT - 1);
    check_out("inv_early", 4'h2, 1'b1, 1'b0, 1'b0);
    cycles(1);
    check_out("inv_commit", 4'h2, 1'b0, 1'b1, 1'b1);
    cycles(1);
    check("inv_change_low", 32'(change), 32'd0);

    // Sweep all glyphs, each held 8 cycles.
    for (int g = 0; g < 16; g++) begin
      segs = glyphs[g];
      for (int c = 1; c <= 8; c++) begin
        cycles(1);
        if (c == LAT - 1) check("sweep_early.change", 32'(change), 32'd0);
        if (c == LAT) check_out($sformatf("sweep_%0h", g), 4'(g), 1'b1, 1'b0, 1'b1);
        if (c == LAT + 1) check("sweep_after.change", 32'(change), 32'd0);
      end
    end

    // Blank acceptance: clears flags, keeps nibble, pulses change.
    segs = 7'h00;
    cycles(LAT);
    check_out("blank_commit", 4'hF, 1'b0, 1'b0, 1'b1);
    cycles(2);
    check_out("blank_hold", 4'hF, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-cycle while 71 is settling.
    segs = 7'h71;
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    check_out("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(LAT - 1);
    check_out("rst_early", 4'h0, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_out("rst_commit", 4'hF, 1'b1, 1'b0, 1'b1);
    cycles(1);
    check_out("rst_after", 4'hF, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
